uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame (legal 1..2).
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bclk  input  1  baud clock from the baud generator; one bit period = one bclk rising edge to the next.
REQ-006 tx_data  input  DATA_BITS  byte to send, sampled on accept.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  high only in IDLE; accept occurs when tx_valid & tx_ready on the same clk edge.
REQ-009 tx  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 bclk SHALL be registered once into bclk_q; tick = bclk & ~bclk_q, a one-clk pulse per bclk rising edge.
REQ-012 States SHALL be IDLE, SYNC, START, DATA, PARITY, STOP, encoded in 3 bits.
REQ-013 IDLE: tx=1, tx_ready=1; on accept, latch tx_data into shift register, go to SYNC next clk; tx_ready low the following cycle.
REQ-014 SYNC: tx=1; on tick, tx<=0 and go to START, so the start bit always begins on a baud boundary.
REQ-015 START: on tick, tx<=shift[0] (LSB first), bit counter<=0, go to DATA.
REQ-016 DATA: on tick, if counter==DATA_BITS-1 go to PARITY (macro defined) or drive tx<=1 and go to STOP; else shift right, counter+1, tx<=next bit.
REQ-017 PARITY: on tick, tx<=1, go to STOP.
REQ-018 STOP: counts STOP_BITS ticks with tx=1; on the final tick, go to IDLE; tx_ready rises the clk after that tick.
REQ-019 Non-tick cycles SHALL hold state, counters and tx unchanged.
REQ-020 tx_valid in any state but IDLE SHALL be ignored; tx_data changes after accept SHALL not affect the frame.
REQ-021 A tick on the same clk as accept SHALL NOT advance SYNC; SYNC waits for the next tick.
REQ-022 Frame length from the first START tick to return to IDLE SHALL equal 1+DATA_BITS+P+STOP_BITS bit periods (P=1 with parity, else 0).
REQ-023 bclk held static SHALL stall the FSM indefinitely, with no timeout.

Reset
REQ-024 rst_n low SHALL immediately force: state=IDLE, tx=1, tx_ready=1, busy=0, bclk_q=0, counters=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; tx returns high asynchronously and no partial frame resumes after release.
REQ-026 After release, the first accept SHALL be possible on the first clk edge.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state is compiled in; the parity bit is even parity (XOR of the DATA_BITS latched bits), sent after the last data bit.
REQ-028 Macro undefined: PARITY state and XOR logic are absent; DATA goes directly to STOP; the frame is 8N1 for defaults.

Verification
REQ-029 Defaults, no macro, bclk period 20 clk, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 20 clk; tx_ready low for the whole frame.
REQ-030 Macro defined, send 0x03 -> bits 0,1,1,0,0,0,0,0,0,0(parity),1(stop); send 0x07 -> parity bit 1.
REQ-031 tx_valid held high with 0x55 then 0xAA -> exactly two frames back-to-back, the second SYNC waits for the next tick, and 0xAA is not lost or duplicated.
REQ-032 rst_n pulsed low during the 4th data bit -> tx=1 within the same cycle and tx_ready=1; the next accepted byte 0x3C is sent as a complete frame.
REQ-033 DATA_BITS=7, STOP_BITS=2, send 0x7F -> 1 start, 7 ones, 2 stop periods; tx_ready rises the clk after the second stop tick.
REQ-034 Accept on the same clk as a tick -> start bit begins at the following tick, not the coincident one.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte handshake between a producer and the UART transmitter.
// The producer (master) drives tx_data/tx_valid; the transmitter (slave)
// returns tx_ready. A byte is accepted when tx_valid & tx_ready meet on a clk edge.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter paced by an external baud clock (bclk).
// Frame: 1 start bit (0), DATA_BITS data bits LSB first, optional even parity
// bit, STOP_BITS stop bits (1). The line idles high.
// Optional feature macro: UART_TX_PARITY_EN -- when defined, an even parity
// bit (XOR of the latched data bits) is sent after the last data bit.
// bclk rising edges are turned into one-clk ticks; every bit boundary lands
// on a tick, and the FSM only moves on ticks (a static bclk stalls it).
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     bclk,
   uart_tx_if.slave s_if,
   output logic     tx,
   output logic     busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SYNC   = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif
   localparam logic [2:0] ST_STOP   = 3'd5;

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   logic [2:0]           r_state;
   logic                 r_bclk_q;
   logic                 r_tx;
   logic                 r_ready;
   logic                 r_busy;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 w_tick;

`ifdef UART_TX_PARITY_EN
   logic                 r_parity;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic f_even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`endif

   // Delay bclk by one clk so its rising edge can be detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bclk_q <= 1'b0;
      end else begin
         r_bclk_q <= bclk;
      end
   end

   assign w_tick = bclk & ~r_bclk_q;

   // Frame sequencer: accept in IDLE, then advance one bit per baud tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_shift    <= {DATA_BITS{1'b0}};
         r_bit_cnt  <= 3'd0;
         r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A tick coinciding with accept is ignored: SYNC waits for the next one.
               r_tx <= 1'b1;
               if (s_if.tx_valid && r_ready) begin
                  r_shift <= s_if.tx_data;
`ifdef UART_TX_PARITY_EN
                  r_parity <= f_even_parity(s_if.tx_data);
`endif
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (w_tick) begin
                  r_tx    <= 1'b0;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_tx      <= r_shift[0];
                  r_bit_cnt <= 3'd0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= ST_PARITY;
`else
                     r_tx       <= 1'b1;
                     r_stop_cnt <= 1'b0;
                     r_state    <= ST_STOP;
`endif
                  end else begin
                     r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                     r_tx      <= r_shift[1];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
                  r_state    <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  if (r_stop_cnt == LAST_STOP) begin
                     r_stop_cnt <= 1'b0;
                     r_ready    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_tx       <= 1'b1;
               r_ready    <= 1'b1;
               r_busy     <= 1'b0;
               r_bit_cnt  <= 3'd0;
               r_stop_cnt <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx            = r_tx;
   assign busy          = r_busy;
   assign s_if.tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- randomized self-checking bench for uart_tx.
// A frame-level reference model (queue of expected line levels popped on each
// baud tick) is compared against tx/tx_ready/busy every clk.
// Two instances: 8 data/1 stop and 7 data/2 stop; one is exercised at a time.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       bclk     = 1'b0;
   logic       tb_valid = 1'b0;
   logic [7:0] tb_data  = 8'h00;
   logic       tb_sel   = 1'b0;
   logic       bclk_run = 1'b1;
   logic       mon_en   = 1'b0;
   int         bclk_cnt = 0;
   logic       tx0, busy0, tx1, busy1;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic       m_busy   = 1'b0;
   logic       m_tx     = 1'b1;
   logic       m_bclk_q = 1'b0;
   logic       m_tick;
   int         m_pops   = 0;
   int         m_acc    = 0;
   logic       m_q[$];

   uart_tx_if #(.DATA_BITS(8)) if0 ();
   uart_tx_if #(.DATA_BITS(7)) if1 ();

   assign if0.tx_valid = tb_valid & ~tb_sel;
   assign if0.tx_data  = tb_data;
   assign if1.tx_valid = tb_valid & tb_sel;
   assign if1.tx_data  = tb_data[6:0];

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bclk(bclk), .s_if(if0), .tx(tx0), .busy(busy0)
   );

   uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .bclk(bclk), .s_if(if1), .tx(tx1), .busy(busy1)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // clk: 10 time units
   initial forever #5 clk = ~clk;

   // baud clock: 20 clk period, 50% duty, pausable
   initial forever begin
      @(negedge clk);
      if (bclk_run) begin
         bclk_cnt = (bclk_cnt + 1) % 20;
         bclk     = (bclk_cnt < 10);
      end
   end

   // frame-level reference model
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_q.delete();
         m_busy   = 1'b0;
         m_tx     = 1'b1;
         m_bclk_q = 1'b0;
         m_pops   = 0;
      end else begin
         m_tick   = bclk & ~m_bclk_q;
         m_bclk_q = bclk;
         if (!m_busy) begin
            if (tb_valid) begin
               int db;
               int sb;
               logic par;
               db  = tb_sel ? 7 : 8;
               sb  = tb_sel ? 2 : 1;
               par = 1'b0;
               m_q.delete();
               m_q.push_back(1'b0);
               for (int i = 0; i < db; i++) begin
                  m_q.push_back(tb_data[i]);
                  par = par ^ tb_data[i];
               end
               if (P == 1) m_q.push_back(par);
               for (int i = 0; i < sb; i++) m_q.push_back(1'b1);
               m_busy = 1'b1;
               m_pops = 0;
               m_acc++;
            end
         end else if (m_tick) begin
            if (m_q.size() > 0) begin
               m_tx = m_q.pop_front();
               m_pops++;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
   end

   // per-cycle comparison of the active instance against the model
   initial forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
         chk_eq("tx",    tb_sel ? tx1 : tx0, m_tx);
         chk_eq("ready", tb_sel ? if1.tx_ready : if0.tx_ready, !m_busy);
         chk_eq("busy",  tb_sel ? busy1 : busy0, m_busy);
      end
   end

   task automatic wait_idle(input int bound, input bit noise);
      int n;
      n = 0;
      while (m_busy && n < bound) begin
         @(negedge clk);
         n++;
         if (noise) begin
            tb_data  = 8'($urandom);
            tb_valid = ($urandom_range(0, 3) == 0) && (m_q.size() > 2);
         end
      end
      tb_valid = 1'b0;
      chk_eq("idle_timeout", m_busy, 1'b0);
   endtask

   task automatic send(input logic [7:0] d, input bit noise);
      @(negedge clk);
      tb_data  = d;
      tb_valid = 1'b1;
      @(negedge clk);
      chk_eq("accept", m_busy, 1'b1);
      tb_valid = 1'b0;
      wait_idle(2000, noise);
   endtask

   // send and measure start-bit fall to tx_ready rise in clk cycles
   task automatic send_timed(input logic [7:0] d, input int nbits);
      int n;
      @(negedge clk);
      tb_data  = d;
      tb_valid = 1'b1;
      @(negedge clk);
      tb_valid = 1'b0;
      n = 0;
      while ((tb_sel ? tx1 : tx0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk_eq("start_seen", tb_sel ? tx1 : tx0, 1'b0);
      n = 0;
      while (!(tb_sel ? if1.tx_ready : if0.tx_ready) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk_eq("frame_len", n, nbits * 20);
   endtask

   initial begin
      int a0;
      int n;
      // reset state
      repeat (3) @(negedge clk);
      chk_eq("rst_tx0", tx0, 1'b1);
      chk_eq("rst_ready0", if0.tx_ready, 1'b1);
      chk_eq("rst_busy0", busy0, 1'b0);
      chk_eq("rst_tx1", tx1, 1'b1);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // 0xA5 single frame, also timed
      send_timed(8'hA5, 1 + 8 + P + 1);
      wait_idle(100, 1'b0);

      // parity patterns (odd and even ones count)
      send_timed(8'h03, 1 + 8 + P + 1);
      send(8'h07, 1'b0);

      // randomized frames with noise on tx_data/tx_valid during the frame
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(0, 25)) @(negedge clk);
         send(8'($urandom), 1'b1);
      end

      // tx_valid held high across two bytes
      @(negedge clk);
      a0       = m_acc;
      tb_data  = 8'h55;
      tb_valid = 1'b1;
      @(negedge clk);
      tb_data  = 8'hAA;
      n = 0;
      while (m_acc < a0 + 2 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tb_valid = 1'b0;
      chk_eq("two_accepts", m_acc - a0, 2);
      wait_idle(2000, 1'b0);
      repeat (30) @(negedge clk);
      chk_eq("no_dup", m_acc - a0, 2);

      // accept on the same edge as a tick
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (bclk_cnt != 0 && n < 100);
      tb_data  = 8'hC3;
      tb_valid = 1'b1;
      @(negedge clk);
      tb_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk_eq("sync_wait", tx0, 1'b1);
      wait_idle(2000, 1'b0);

      // bclk stalled mid-frame
      @(negedge clk);
      tb_data  = 8'h6E;
      tb_valid = 1'b1;
      @(negedge clk);
      tb_valid = 1'b0;
      n = 0;
      while (m_pops < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      bclk_run = 1'b0;
      repeat (300) @(negedge clk);
      chk_eq("stall_busy", busy0, 1'b1);
      bclk_run = 1'b1;
      wait_idle(2000, 1'b0);

      // reset during the 4th data bit
      @(negedge clk);
      tb_data  = 8'h96;
      tb_valid = 1'b1;
      @(negedge clk);
      tb_valid = 1'b0;
      n = 0;
      while (m_pops < 5 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("arst_tx", tx0, 1'b1);
      chk_eq("arst_ready", if0.tx_ready, 1'b1);
      chk_eq("arst_busy", busy0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tb_data  = 8'h3C;
      tb_valid = 1'b1;
      @(negedge clk);
      chk_eq("first_accept", busy0, 1'b1);
      tb_valid = 1'b0;
      wait_idle(2000, 1'b0);

      // 7 data bits, 2 stop bits instance
      repeat (3) @(negedge clk);
      tb_sel = 1'b1;
      send_timed(8'h7F, 1 + 7 + P + 2);
      wait_idle(100, 1'b0);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 25)) @(negedge clk);
         send(8'($urandom), 1'b1);
      end
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
